// File: rtl/uart_tx_engine_if.sv
// Word handshake between a sender and the UART transmit engine.
// Ports: i_data/i_valid from the sender, o_ready back from the engine.
interface uart_tx_engine_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one word per handshake -> start, data LSB first,
// optional parity, one stop bit.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : i_data, i_valid in; o_ready out
//   o_serial   : registered serial line, idle high
//   o_busy     : frame in progress
//   o_done     : one-cycle pulse in the first idle cycle after the stop bit
//   state      : current FSM state for debug
module uart_tx_engine #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_ODD       = 0,
    parameter int CLOCKS_PER_BIT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_engine_if.slave      bus,
    output logic                 o_serial,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           state
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
    localparam logic PE_BIT  = (PARITY_ENABLED != 0);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [BW-1:0]               bit_q, bit_d;
    logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                        par_q, par_d;
    logic                        serial_q, serial_d;
    logic                        done_q, done_d;
    logic                        cnt_last;
    logic                        bit_last;

    assign cnt_last = (cnt_q == CW'(CLOCKS_PER_BIT - 1));
    assign bit_last = (bit_q == BW'(INPUT_DATA_WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (bus.i_valid) begin
                    shift_d = bus.i_data;
                    par_d   = (^bus.i_data) ^ ODD_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_last) begin
                        bit_d   = '0;
                        state_d = PE_BIT ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so o_serial is a register
    // yet already shows the new bit in the first cycle of that bit.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_serial    = serial_q;
    assign state       = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three configurations checked against a
// frame model built from start/data/parity/stop bit rules.
module tb_uart_tx_engine;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] val;
    logic [7:0] dat [3];
    logic [2:0] ser, rdy, bsy, dn;
    logic [2:0] st_a, st_b, st_c;

    int n_assert = 0;
    int n_fail   = 0;

    logic       exp_bit [512];
    logic [2:0] exp_st  [512];

    uart_tx_engine_if #(.WIDTH(8)) bus_a ();
    uart_tx_engine_if #(.WIDTH(8)) bus_b ();
    uart_tx_engine_if #(.WIDTH(8)) bus_c ();

    assign bus_a.i_valid = val[0];
    assign bus_a.i_data  = dat[0];
    assign rdy[0]        = bus_a.o_ready;
    assign bus_b.i_valid = val[1];
    assign bus_b.i_data  = dat[1];
    assign rdy[1]        = bus_b.o_ready;
    assign bus_c.i_valid = val[2];
    assign bus_c.i_data  = dat[2];
    assign rdy[2]        = bus_c.o_ready;

    uart_tx_engine #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1),
        .PARITY_ODD(0), .CLOCKS_PER_BIT(4)
    ) u_a (
        .clk(clk), .reset(rst[0]), .bus(bus_a),
        .o_serial(ser[0]), .o_busy(bsy[0]),
        .o_done(dn[0]), .state(st_a)
    );

    uart_tx_engine #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1),
        .PARITY_ODD(1), .CLOCKS_PER_BIT(1)
    ) u_b (
        .clk(clk), .reset(rst[1]), .bus(bus_b),
        .o_serial(ser[1]), .o_busy(bsy[1]),
        .o_done(dn[1]), .state(st_b)
    );

    uart_tx_engine #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(0),
        .PARITY_ODD(0), .CLOCKS_PER_BIT(4)
    ) u_c (
        .clk(clk), .reset(rst[2]), .bus(bus_c),
        .o_serial(ser[2]), .o_busy(bsy[2]),
        .o_done(dn[2]), .state(st_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(int c);
        return (c == 1) ? 1 : 4;
    endfunction

    function automatic logic pe_of(int c);
        return (c != 2);
    endfunction

    function automatic logic odd_of(int c);
        return (c == 1);
    endfunction

    function automatic logic [2:0] st_of(int c);
        case (c)
            0:       return st_a;
            1:       return st_b;
            default: return st_c;
        endcase
    endfunction

    // Expected line level and state for every cycle of one frame.
    function automatic int build(int c, logic [7:0] w);
        logic       b [$];
        logic [2:0] s [$];
        int n = 0;
        b.push_back(1'b0); s.push_back(3'd1);
        for (int i = 0; i < 8; i++) begin
            b.push_back(w[i]); s.push_back(3'd2);
        end
        if (pe_of(c)) begin
            b.push_back((^w) ^ odd_of(c)); s.push_back(3'd3);
        end
        b.push_back(1'b1); s.push_back(3'd4);
        for (int k = 0; k < b.size(); k++) begin
            for (int r = 0; r < cpb_of(c); r++) begin
                exp_bit[n] = b[k];
                exp_st[n]  = s[k];
                n++;
            end
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(int c, logic done_exp);
        chk($sformatf("c%0d idle serial", c), 8'(ser[c]), 8'd1);
        chk($sformatf("c%0d idle state", c), 8'(st_of(c)), 8'd0);
        chk($sformatf("c%0d idle ready", c), 8'(rdy[c]), 8'd1);
        chk($sformatf("c%0d idle busy", c), 8'(bsy[c]), 8'd0);
        chk($sformatf("c%0d idle done", c), 8'(dn[c]), 8'(done_exp));
    endtask

    // Word already accepted; watch the whole frame and the done cycle.
    task automatic check_frame(int c, logic [7:0] w, bit toggle,
                               bit chain, logic [7:0] cw);
        int len = build(c, w);
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            chk($sformatf("c%0d w%0h serial[%0d]", c, w, n),
                8'(ser[c]), 8'(exp_bit[n]));
            chk($sformatf("c%0d w%0h state[%0d]", c, w, n),
                8'(st_of(c)), 8'(exp_st[n]));
            chk($sformatf("c%0d w%0h ready[%0d]", c, w, n),
                8'(rdy[c]), 8'd0);
            chk($sformatf("c%0d w%0h busy[%0d]", c, w, n),
                8'(bsy[c]), 8'd1);
            chk($sformatf("c%0d w%0h done[%0d]", c, w, n),
                8'(dn[c]), 8'd0);
            if (n == len - 1) begin
                val[c] = chain;
                dat[c] = cw;
            end else if (toggle) begin
                val[c] = 1'($urandom);
                dat[c] = 8'($urandom);
            end else begin
                val[c] = 1'b0;
            end
        end
        @(negedge clk);
        chk_idle(c, 1'b1);
    endtask

    task automatic send(int c, logic [7:0] w, bit toggle,
                        bit chain, logic [7:0] cw);
        @(negedge clk);
        chk_idle(c, 1'b0);
        val[c] = 1'b1;
        dat[c] = w;
        check_frame(c, w, toggle, chain, cw);
    endtask

    initial begin
        rst = 3'b111;
        val = 3'b000;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 3; c++) chk_idle(c, 1'b0);
        rst = 3'b000;

        send(0, 8'hA5, 0, 0, 8'h00);
        send(0, 8'h07, 0, 0, 8'h00);
        send(1, 8'h07, 0, 0, 8'h00);
        send(1, 8'hA5, 0, 0, 8'h00);
        send(2, 8'hFF, 0, 0, 8'h00);

        send(0, 8'h55, 0, 1, 8'h3C);
        check_frame(0, 8'h3C, 0, 0, 8'h00);

        send(0, 8'hC3, 1, 0, 8'h00);
        send(1, 8'h5A, 1, 0, 8'h00);

        begin
            int len;
            @(negedge clk);
            val[0] = 1'b1;
            dat[0] = 8'hA5;
            len = build(0, 8'hA5);
            for (int n = 0; n < 18; n++) begin
                @(negedge clk);
                val[0] = 1'b0;
                chk($sformatf("abort serial[%0d]", n),
                    8'(ser[0]), 8'(exp_bit[n]));
                chk($sformatf("abort state[%0d]", n),
                    8'(st_a), 8'(exp_st[n]));
            end
            rst[0] = 1'b1;
            @(negedge clk);
            rst[0] = 1'b0;
            chk_idle(0, 1'b0);
            for (int n = 0; n < len; n++) begin
                @(negedge clk);
                chk($sformatf("abort quiet serial[%0d]", n),
                    8'(ser[0]), 8'd1);
                chk($sformatf("abort quiet done[%0d]", n),
                    8'(dn[0]), 8'd0);
            end
            send(0, 8'h81, 0, 0, 8'h00);
        end

        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                send(c, 8'($urandom), k[0], 0, 8'h00);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
